// File: rtl/adc_capture_pkg.sv
// Shared widths, capture FSM encoding and lane-extraction helper
// for the ADC lane unpacker.
package adc_capture_pkg;

    localparam int SAMPLE_W = 9;
    localparam int LANES    = 4;
    localparam int WORD_W   = SAMPLE_W * LANES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cap_state_t;

    // Lane 0 lives in the least significant bits of the packed word.
    function automatic logic [SAMPLE_W-1:0] lane_of(input logic [WORD_W-1:0] word,
                                                    input logic [1:0]        idx);
        logic [SAMPLE_W-1:0] s;
        s = word[SAMPLE_W-1:0];
        for (int i = 1; i < LANES; i++) begin
            if (idx == 2'(i)) s = word[i*SAMPLE_W +: SAMPLE_W];
        end
        return s;
    endfunction

endpackage

// File: rtl/adc_lane_unpack_if.sv
// Packed-word input and unpacked-sample output handshakes of the lane unpacker.
interface adc_lane_unpack_if;
    import adc_capture_pkg::*;

    logic [WORD_W-1:0]        ANA_ADC_DATA;
    logic                     ANA_ADC_DATA_VLD;
    logic                     ANA_ADC_DATA_RDY;
    logic [SAMPLE_W-1:0]      SAMPLE_DATA;
    logic [$clog2(LANES)-1:0] SAMPLE_IDX;
    logic                     SAMPLE_VLD;
    logic                     SAMPLE_RDY;
    logic                     SAMPLE_LAST;

    // master = word producer / sample consumer, slave = the unpacker
    modport master (
        output ANA_ADC_DATA, ANA_ADC_DATA_VLD, SAMPLE_RDY,
        input  ANA_ADC_DATA_RDY, SAMPLE_DATA, SAMPLE_IDX, SAMPLE_VLD, SAMPLE_LAST
    );

    modport slave (
        input  ANA_ADC_DATA, ANA_ADC_DATA_VLD, SAMPLE_RDY,
        output ANA_ADC_DATA_RDY, SAMPLE_DATA, SAMPLE_IDX, SAMPLE_VLD, SAMPLE_LAST
    );

endinterface

// File: rtl/adc_word_fifo.sv
// Synchronous word FIFO with flush; head word is visible combinationally on rd_data.
module adc_word_fifo #(
    parameter int WORD_W = 36,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)  wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/adc_lane_unpack.sv
// Captures packed 4x9-bit ADC words into a FIFO and replays them as a
// stream of single samples, bounded by a requested sample count.
module adc_lane_unpack
    import adc_capture_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               ADC_CLK500M,
    input  logic               adc96_rstn,
    input  logic               capture_start,
    input  logic [15:0]        capture_len,
    adc_lane_unpack_if.slave   lane_if,
    output logic               capture_busy,
    output logic               capture_done,
    output logic               overflow
);

    cap_state_t        state_q, state_d;
    logic [15:0]       len_q;
    logic [15:0]       sample_cnt_q;
    logic [14:0]       words_q;
    logic [1:0]        lane_q;
    logic              ovf_q;

    logic              fifo_wr, fifo_rd, fifo_flush, fifo_full, fifo_empty;
    logic [WORD_W-1:0] fifo_head;
    logic              start_ok, budget_ok, lane_vld, sample_last, sample_hs;

    assign start_ok    = (state_q == ST_IDLE) && capture_start;
    // Stop taking words once the accepted lanes already cover the request.
    assign budget_ok   = {words_q, 2'b00} < {1'b0, len_q};
    assign lane_vld    = (state_q == ST_RUN) && !fifo_empty;
    assign sample_last = lane_vld && (sample_cnt_q == len_q - 16'd1);
    assign sample_hs   = lane_vld && lane_if.SAMPLE_RDY;

    assign fifo_wr    = (state_q == ST_RUN) && lane_if.ANA_ADC_DATA_VLD && !fifo_full && budget_ok;
    assign fifo_rd    = sample_hs && (lane_q == 2'd3);
    assign fifo_flush = (state_q != ST_RUN) || (sample_hs && sample_last);

    assign lane_if.ANA_ADC_DATA_RDY = (state_q != ST_RUN) || (!fifo_full && budget_ok);
    assign lane_if.SAMPLE_VLD       = lane_vld;
    assign lane_if.SAMPLE_DATA      = lane_vld ? lane_of(fifo_head, lane_q) : '0;
    assign lane_if.SAMPLE_IDX       = lane_q;
    assign lane_if.SAMPLE_LAST      = sample_last;

    assign capture_busy = (state_q == ST_RUN);
    assign capture_done = (state_q == ST_DONE);
    assign overflow     = ovf_q;

    adc_word_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (ADC_CLK500M),
        .rst_n   (adc96_rstn),
        .flush   (fifo_flush),
        .wr_en   (fifo_wr),
        .wr_data (lane_if.ANA_ADC_DATA),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (capture_start) state_d = (capture_len == 16'd0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (sample_hs && sample_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ADC_CLK500M or negedge adc96_rstn) begin
        if (!adc96_rstn) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            sample_cnt_q <= '0;
            words_q      <= '0;
            lane_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                len_q        <= capture_len;
                sample_cnt_q <= '0;
                words_q      <= '0;
                ovf_q        <= 1'b0;
            end else begin
                if (sample_hs) sample_cnt_q <= sample_cnt_q + 16'd1;
                if (fifo_wr)   words_q      <= words_q + 15'd1;
                // A word offered into a full FIFO is lost for good.
                if ((state_q == ST_RUN) && lane_if.ANA_ADC_DATA_VLD && fifo_full && budget_ok)
                    ovf_q <= 1'b1;
            end
            if (fifo_flush)     lane_q <= '0;
            else if (sample_hs) lane_q <= lane_q + 2'd1;
        end
    end

endmodule

// File: tb/tb_adc_lane_unpack.sv
// Self-checking bench for adc_lane_unpack: directed capture scenarios plus
// randomized captures compared every cycle against a queue-based model.
module tb_adc_lane_unpack;

    localparam int DEPTH = 8;
    localparam logic [35:0] WORD_A = {9'd4, 9'd3, 9'd2, 9'd1};
    localparam logic [35:0] WORD_B = {9'd8, 9'd7, 9'd6, 9'd5};

    logic        ADC_CLK500M = 1'b0;
    logic        adc96_rstn  = 1'b1;
    logic        capture_start = 1'b0;
    logic [15:0] capture_len   = '0;
    logic        capture_busy, capture_done, overflow;

    adc_lane_unpack_if bus ();

    adc_lane_unpack #(.DEPTH(DEPTH)) dut (
        .ADC_CLK500M   (ADC_CLK500M),
        .adc96_rstn    (adc96_rstn),
        .capture_start (capture_start),
        .capture_len   (capture_len),
        .lane_if       (bus.slave),
        .capture_busy  (capture_busy),
        .capture_done  (capture_done),
        .overflow      (overflow)
    );

    always #5 ADC_CLK500M = ~ADC_CLK500M;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit check_en = 1'b0;

    // Reference model: capture phase, buffered words, position in head word.
    typedef enum int {M_IDLE, M_RUN, M_DONE} m_state_t;
    m_state_t    m_state = M_IDLE;
    logic [35:0] m_q[$];
    int          m_lane = 0, m_cnt = 0, m_acc = 0, m_len = 0;
    bit          m_ovf = 1'b0;

    logic [11:0] got[$];
    int done_cnt = 0, vld_cnt = 0, rdy_low_cnt = 0;

    task automatic checkOutput(input string tag, input logic [35:0] actual, input logic [35:0] expected);
        total_cnt++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        else
            pass_cnt++;
    endtask

    function automatic bit exp_vld();
        return (m_state == M_RUN) && (m_q.size() > 0);
    endfunction

    function automatic bit exp_rdy();
        return (m_state != M_RUN) || ((m_q.size() < DEPTH) && (m_acc * 4 < m_len));
    endfunction

    function automatic logic [35:0] exp_data();
        if (!exp_vld()) return 36'd0;
        return (m_q[0] >> (9 * m_lane)) & 36'h1FF;
    endfunction

    function automatic bit exp_last();
        return exp_vld() && (m_cnt == m_len - 1);
    endfunction

    always @(posedge ADC_CLK500M or negedge adc96_rstn) begin
        bit hs, last, wr;
        if (!adc96_rstn) begin
            m_state = M_IDLE; m_q.delete();
            m_lane = 0; m_cnt = 0; m_acc = 0; m_len = 0; m_ovf = 1'b0;
        end else begin
            case (m_state)
                M_IDLE: if (capture_start) begin
                    m_ovf = 1'b0; m_len = int'(capture_len);
                    m_cnt = 0; m_acc = 0; m_lane = 0; m_q.delete();
                    m_state = (capture_len == 16'd0) ? M_DONE : M_RUN;
                end
                M_RUN: begin
                    hs   = exp_vld() && bus.SAMPLE_RDY;
                    last = exp_last();
                    wr   = bus.ANA_ADC_DATA_VLD && exp_rdy();
                    if (bus.ANA_ADC_DATA_VLD && m_q.size() == DEPTH && m_acc * 4 < m_len) m_ovf = 1'b1;
                    if (hs && last) begin
                        m_q.delete(); m_lane = 0; m_state = M_DONE;
                    end else begin
                        if (hs) begin
                            m_cnt++;
                            if (m_lane == 3) begin
                                void'(m_q.pop_front());
                                m_lane = 0;
                            end else m_lane++;
                        end
                        if (wr) begin
                            m_q.push_back(bus.ANA_ADC_DATA);
                            m_acc++;
                        end
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
    end

    // Outputs are compared mid-cycle, away from both edges of the stimulus.
    always @(negedge ADC_CLK500M) begin
        if (check_en) begin
            checkOutput("data_rdy", bus.ANA_ADC_DATA_RDY, exp_rdy());
            checkOutput("sample_vld", bus.SAMPLE_VLD, exp_vld());
            checkOutput("sample_data", bus.SAMPLE_DATA, exp_data());
            checkOutput("sample_idx", bus.SAMPLE_IDX, exp_vld() ? m_lane : 0);
            checkOutput("sample_last", bus.SAMPLE_LAST, exp_last());
            checkOutput("busy", capture_busy, m_state == M_RUN);
            checkOutput("done", capture_done, m_state == M_DONE);
            checkOutput("overflow", overflow, m_ovf);
            if (bus.SAMPLE_VLD && bus.SAMPLE_RDY)
                got.push_back({bus.SAMPLE_LAST, bus.SAMPLE_IDX, bus.SAMPLE_DATA});
            if (capture_done) done_cnt++;
            if (bus.SAMPLE_VLD) vld_cnt++;
            if (capture_busy && !bus.ANA_ADC_DATA_RDY) rdy_low_cnt++;
        end
    end

    task automatic applyStimulus(input bit start, input logic [15:0] len, input bit vld,
                                 input logic [35:0] word, input bit srdy);
        @(posedge ADC_CLK500M);
        #2;
        capture_start        = start;
        capture_len          = len;
        bus.ANA_ADC_DATA_VLD = vld;
        bus.ANA_ADC_DATA     = word;
        bus.SAMPLE_RDY       = srdy;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 16'd0, 1'b0, 36'd0, 1'b1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_data"}, bus.SAMPLE_DATA, 0);
        checkOutput({tag, "_idx"}, bus.SAMPLE_IDX, 0);
        checkOutput({tag, "_vld"}, bus.SAMPLE_VLD, 0);
        checkOutput({tag, "_last"}, bus.SAMPLE_LAST, 0);
        checkOutput({tag, "_busy"}, capture_busy, 0);
        checkOutput({tag, "_done"}, capture_done, 0);
        checkOutput({tag, "_ovf"}, overflow, 0);
        checkOutput({tag, "_rdy"}, bus.ANA_ADC_DATA_RDY, 1);
    endtask

    task automatic resetDut(input string tag);
        adc96_rstn = 1'b0;
        #1;
        checkResetValues(tag);
        repeat (2) @(posedge ADC_CLK500M);
        #2;
        adc96_rstn = 1'b1;
    endtask

    task automatic waitDone(input int budget, input bit toggle, output int cycles);
        bit phase;
        phase  = 1'b1;
        cycles = 0;
        while (capture_done !== 1'b1 && cycles < budget) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 36'd0, toggle ? phase : 1'b1);
            phase = ~phase;
            cycles++;
        end
        if (capture_done !== 1'b1) checkOutput("done_timeout", capture_done, 1'b1);
        idleCycle();
    endtask

    task automatic runTwoWordCapture(input int len, input bit toggle, output int cycles);
        got.delete();
        applyStimulus(1'b1, 16'(len), 1'b0, 36'd0, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b1, WORD_A, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b1, WORD_B, !toggle);
        waitDone(60, toggle, cycles);
    endtask

    task automatic checkSamples(input string tag, input int n);
        checkOutput({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            checkOutput({tag, "_value"}, got[i][8:0], i + 1);
            checkOutput({tag, "_lane"}, got[i][10:9], i % 4);
            checkOutput({tag, "_lastflag"}, got[i][11], i == n - 1);
        end
    endtask

    initial begin
        int cycles, done_base, vld_base, len;
        logic [35:0] w;

        bus.ANA_ADC_DATA = '0; bus.ANA_ADC_DATA_VLD = 1'b0; bus.SAMPLE_RDY = 1'b1;
        #2;
        check_en = 1'b1;
        resetDut("reset");

        $display("[TB] two words, len 8");
        done_base = done_cnt;
        runTwoWordCapture(8, 1'b0, cycles);
        checkSamples("len8", 8);
        checkOutput("len8_done_pulses", done_cnt - done_base, 1);

        $display("[TB] two words, len 6");
        runTwoWordCapture(6, 1'b0, cycles);
        checkSamples("len6", 6);
        checkOutput("len6_fifo_empty", dut.u_fifo.empty, 1'b1);

        $display("[TB] len 4 with alternating SAMPLE_RDY");
        vld_base = vld_cnt;
        runTwoWordCapture(4, 1'b1, cycles);
        checkSamples("len4", 4);
        checkOutput("len4_vld_cycles", vld_cnt - vld_base, 8);

        $display("[TB] zero-length capture");
        vld_base  = vld_cnt;
        done_base = done_cnt;
        applyStimulus(1'b1, 16'd0, 1'b0, 36'd0, 1'b1);
        waitDone(10, 1'b0, cycles);
        checkOutput("len0_latency", cycles, 1);
        checkOutput("len0_no_vld", vld_cnt - vld_base, 0);
        checkOutput("len0_done_pulses", done_cnt - done_base, 1);

        $display("[TB] overflow with len 64");
        got.delete();
        rdy_low_cnt = 0;
        applyStimulus(1'b1, 16'd64, 1'b0, 36'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            w = 36'({$urandom(), $urandom()});
            applyStimulus(1'b0, 16'd0, 1'b1, w, 1'b1);
        end
        for (int i = 0; i < 40; i++) idleCycle();
        checkOutput("ovf_set", overflow, 1'b1);
        checkOutput("ovf_rdy_dropped", rdy_low_cnt > 0, 1'b1);
        checkOutput("ovf_still_busy", capture_busy, 1'b1);
        checkOutput("ovf_partial", got.size() < 64, 1'b1);
        resetDut("ovf_reset");

        $display("[TB] reset after three samples");
        got.delete();
        done_base = done_cnt;
        applyStimulus(1'b1, 16'd8, 1'b0, 36'd0, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b1, WORD_A, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b1, WORD_B, 1'b1);
        cycles = 0;
        while (got.size() < 3 && cycles < 20) begin
            idleCycle();
            cycles++;
        end
        checkOutput("abort_three", got.size(), 3);
        resetDut("abort");
        idleCycle();
        checkOutput("abort_no_done", done_cnt - done_base, 0);
        runTwoWordCapture(8, 1'b0, cycles);
        checkSamples("after_abort", 8);

        $display("[TB] randomized captures");
        for (int r = 0; r < 10; r++) begin
            got.delete();
            len = $urandom_range(1, 40);
            applyStimulus(1'b1, 16'(len), $urandom_range(0, 1) == 1, 36'({$urandom(), $urandom()}), 1'b1);
            cycles = 0;
            while (capture_done !== 1'b1 && cycles < 600) begin
                applyStimulus($urandom_range(0, 7) == 0, 16'($urandom_range(0, 40)),
                              $urandom_range(0, 1) == 1, 36'({$urandom(), $urandom()}),
                              $urandom_range(0, 3) != 0);
                cycles++;
            end
            checkOutput("rnd_done", capture_done, 1'b1);
            idleCycle();
            checkOutput("rnd_count", got.size(), len);
            if (got.size() > 0) checkOutput("rnd_final_last", got[got.size()-1][11], 1'b1);
        end

        idleCycle();
        check_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/adc_lane_unpack.md
ADC_LANE_UNPACK -- requirements
Module: adc_lane_unpack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning word-FIFO depth in 36-bit words (power of two, >=2).
REQ-002 SHALL have port ADC_CLK500M  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port adc96_rstn  in  1  asynchronous active-low reset.
REQ-004 SHALL have port capture_start  in  1  single-cycle request to begin a capture.
REQ-005 SHALL have port capture_len  in  16  samples to deliver; sampled only on accepted capture_start.
REQ-006 SHALL have port ANA_ADC_DATA  in  36  packed word {s3,s2,s1,s0}, s0 = bits 8:0.
REQ-007 SHALL have port ANA_ADC_DATA_VLD  in  1  packed word valid.
REQ-008 SHALL have port ANA_ADC_DATA_RDY  out  1  block can accept a word this cycle.
REQ-009 SHALL have port SAMPLE_DATA  out  9  unpacked sample.
REQ-010 SHALL have port SAMPLE_IDX  out  2  lane position of SAMPLE_DATA within its source word.
REQ-011 SHALL have port SAMPLE_VLD  out  1 / SAMPLE_RDY  in  1  downstream handshake.
REQ-012 SHALL have port SAMPLE_LAST  out  1  marks final sample of the capture.
REQ-013 SHALL have ports capture_busy  out  1, capture_done  out  1 (one-cycle pulse), overflow  out  1 (sticky).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on capture_start with capture_len!=0; IDLE->DONE on capture_start with capture_len==0; RUN->DONE on the handshake of the SAMPLE_LAST sample; DONE->IDLE unconditionally next cycle.
REQ-015 SHALL ignore capture_start in RUN and DONE.
REQ-016 In IDLE/DONE SHALL drive ANA_ADC_DATA_RDY=1 and discard incoming words; FIFO held empty.
REQ-017 In RUN SHALL accept a word when VLD&&RDY; RDY = FIFO not full AND words_accepted*4 < capture_len.
REQ-018 In RUN, VLD=1 while FIFO full (and word budget not exhausted) SHALL set overflow and drop the word; overflow cleared only on accepted capture_start or reset.
REQ-019 SHALL emit lanes of each word in order s0,s1,s2,s3 with SAMPLE_IDX 0..3; next word's s0 follows s3 with no bubble when FIFO non-empty.
REQ-020 A word written into an empty FIFO SHALL present its s0 with SAMPLE_VLD=1 on the following cycle (1-cycle latency).
REQ-021 SAMPLE_DATA/IDX/LAST SHALL hold stable while SAMPLE_VLD=1 and SAMPLE_RDY=0.
REQ-022 SHALL count handshaked samples in a 16-bit counter; SAMPLE_LAST=1 exactly when count==capture_len-1.
REQ-023 On the SAMPLE_LAST handshake SHALL discard remaining lanes of that word and flush the FIFO.
REQ-024 capture_busy SHALL equal (state==RUN); capture_done SHALL be 1 only in DONE.
REQ-025 Simultaneous FIFO write and read SHALL be supported at full and empty boundaries without loss.

Reset
REQ-026 On adc96_rstn low SHALL enter IDLE, empty FIFO, clear counters, and drive SAMPLE_DATA=0, SAMPLE_IDX=0, SAMPLE_VLD=0, SAMPLE_LAST=0, capture_busy=0, capture_done=0, overflow=0; ANA_ADC_DATA_RDY=1.
REQ-027 Reset asserted mid-RUN SHALL abort the capture with no capture_done pulse.

Structure
REQ-028 SHALL take SAMPLE_W=9, LANES=4, WORD_W=36 and the FSM state encoding from shared package adc_capture_pkg.
REQ-029 SHALL instantiate one synchronous FIFO sub-module adc_word_fifo (WORD_W x DEPTH, full/empty, flush input).

Verification
REQ-030 capture_len=8, two words 36'h{004,003,002,001} then {008,007,006,005}, SAMPLE_RDY=1 -> samples 1..8, IDX 0,1,2,3,0,1,2,3, LAST on 8, capture_done one cycle later.
REQ-031 capture_len=6, same two words -> samples 1..6, LAST on 6, lanes 7,8 discarded, FIFO empty after DONE.
REQ-032 capture_len=64, VLD held 1 for 20 cycles, SAMPLE_RDY=1 -> RDY drops at full, overflow=1, 64 samples still delivered from accepted words only if available, else busy remains until reset.
REQ-033 SAMPLE_RDY toggled 1/0 every cycle, capture_len=4 -> each sample held two cycles, order unchanged.
REQ-034 capture_len=0 -> no SAMPLE_VLD, capture_done pulses one cycle after capture_start.
REQ-035 adc96_rstn low after 3 of 8 samples -> all outputs to reset values, no capture_done, next capture_start works normally.
